// File: rtl/multi_dma_r_pkg.sv
// multi_dma_r_pkg: FSM encoding, FIFO depth and burst sizing shared by the
// multi-channel read DMA.
package multi_dma_r_pkg;

    typedef enum logic [2:0] {IDLE, ARB, REQ, DATA, DONE} state_t;

    localparam int FW = 8;

    function automatic logic [31:0] burst_len(input logic [31:0] rem, input int bl);
        return (rem < (32'd1 << bl)) ? rem : (32'd1 << bl);
    endfunction

endpackage

// File: rtl/multi_dma_r_fifo.sv
// xlib_xyz_fifo: 2**FW-deep first-word-fall-through FIFO exposing its
// occupancy so the arbiter can check free space before a burst.
module xlib_xyz_fifo #(
    parameter int W  = 33,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          val,
    output logic [FW:0]   cnt
);

    logic [W-1:0]  mem [2**FW];
    logic [FW-1:0] wptr;
    logic [FW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign val     = cnt != '0;
    assign do_pop  = pop && val;
    assign do_push = push && !cnt[FW];
    assign dout    = mem[rptr];

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            cnt <= cnt + (FW+1)'(do_push) - (FW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/multi_dma_r.sv
// multi_dma_r: round-robin multi-channel read DMA; one burst outstanding at a
// time, each channel's words land in its own FIFO and stream out with eof.
module multi_dma_r
    import multi_dma_r_pkg::*;
#(
    parameter int AW = 32,
    parameter int AL = 2,
    parameter int BL = 3,
    parameter int CH = 2,
    parameter int DW = 8 * (2 ** AL),
    parameter int FW = multi_dma_r_pkg::FW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_rst_n,
    input  logic [CH-1:0]    pio_adr_we,
    input  logic [31:0]      pio_d,
    output logic [CH*32-1:0] pio_adr,
    input  logic             pio_len_we,
    output logic             dma_done,
    output logic [CH-1:0]    dma_val,
    input  logic [CH-1:0]    dma_rdy,
    output logic [CH-1:0]    dma_eof,
    output logic [CH*DW-1:0] dma_d,
    output logic             bus_rval,
    input  logic             bus_rrdy,
    output logic [BL:0]      bus_rlen,
    output logic [AW-1:0]    bus_raddr,
    input  logic             rsp_val,
    input  logic [DW-1:0]    rsp_data
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int RW = FW + BL + 1;

    state_t        state;
    logic [31:0]   adr [CH];
    logic [RW-1:0] rem [CH];
    logic [FW:0]   cnt [CH];
    logic [CW-1:0] g;
    logic [CW-1:0] rr;
    logic [CW-1:0] pick;
    logic [BL:0]   beat;
    logic [CH-1:0] elig;
    logic [CH-1:0] push;
    logic          found;
    logic          all_zero;
    logic          last_beat;
    logic          eof;

    assign dma_done  = state == DONE;
    assign last_beat = rsp_val && beat == bus_rlen - 1'b1;
    // rem[g] was already reduced at request acceptance, so zero marks the final burst
    assign eof       = last_beat && rem[g] == '0;

    always_comb begin
        found    = 1'b0;
        pick     = rr;
        all_zero = 1'b1;
        for (int i = 0; i < CH; i++) begin
            all_zero = all_zero && rem[i] == '0;
            if (!found && elig[(int'(rr) + i) % CH]) begin
                found = 1'b1;
                pick  = CW'((int'(rr) + i) % CH);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            g         <= '0;
            rr        <= '0;
            beat      <= '0;
            bus_rval  <= 1'b0;
            bus_raddr <= '0;
            bus_rlen  <= '0;
            for (int i = 0; i < CH; i++) begin
                adr[i] <= '0;
                rem[i] <= '0;
            end
        end else if (!bus_rst_n) begin
            state    <= IDLE;
            rr       <= '0;
            bus_rval <= 1'b0;
            for (int i = 0; i < CH; i++) rem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    for (int i = 0; i < CH; i++)
                        if (pio_adr_we[i]) adr[i] <= {pio_d[31:AL], {AL{1'b0}}};
                    if (pio_len_we) begin
                        for (int i = 0; i < CH; i++) rem[i] <= pio_d[RW-1:0];
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (all_zero) begin
                        state <= DONE;
                    end else if (found) begin
                        g         <= pick;
                        rr        <= (pick == CW'(CH - 1)) ? '0 : pick + 1'b1;
                        bus_rval  <= 1'b1;
                        bus_raddr <= AW'(adr[pick]);
                        bus_rlen  <= (BL+1)'(burst_len(32'(rem[pick]), BL));
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_rrdy) begin
                        bus_rval <= 1'b0;
                        adr[g]   <= adr[g] + (32'(bus_rlen) << AL);
                        rem[g]   <= rem[g] - RW'(bus_rlen);
                        beat     <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (rsp_val) begin
                        beat <= beat + 1'b1;
                        if (last_beat) state <= ARB;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [DW:0] dout;
        // a channel may only request a burst its FIFO can fully absorb
        assign elig[k] = rem[k] != '0 &&
                         32'((FW+1)'(2 ** FW) - cnt[k]) >= burst_len(32'(rem[k]), BL);
        assign push[k] = state == DATA && g == CW'(k) && rsp_val && bus_rst_n;
        xlib_xyz_fifo #(.W(DW + 1), .FW(FW)) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (push[k]),
            .din  ({eof, rsp_data}),
            .pop  (dma_val[k] & dma_rdy[k]),
            .dout (dout),
            .val  (dma_val[k]),
            .cnt  (cnt[k])
        );
        assign dma_d[k*DW +: DW]   = dout[DW-1:0];
        assign dma_eof[k]          = dma_val[k] & dout[DW];
        assign pio_adr[k*32 +: 32] = adr[k];
    end

endmodule

// File: tb/tb_multi_dma_r.sv
// tb_multi_dma_r: directed scenarios against a queue-based model of the
// channel streams, burst schedule and done timing.
module tb_multi_dma_r;

    localparam int CH = 2;
    localparam int DW = 32;
    localparam int BL = 3;
    localparam int AW = 32;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } word_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bus_rst_n = 1'b1;
    logic [CH-1:0]    pio_adr_we = '0;
    logic [31:0]      pio_d = '0;
    logic [CH*32-1:0] pio_adr;
    logic             pio_len_we = 1'b0;
    logic             dma_done;
    logic [CH-1:0]    dma_val;
    logic [CH-1:0]    dma_rdy = '1;
    logic [CH-1:0]    dma_eof;
    logic [CH*DW-1:0] dma_d;
    logic             bus_rval;
    logic             bus_rrdy = 1'b1;
    logic [BL:0]      bus_rlen;
    logic [AW-1:0]    bus_raddr;
    logic             rsp_val = 1'b0;
    logic [DW-1:0]    rsp_data = '0;

    always #5 clk = ~clk;

    multi_dma_r #(.AW(AW), .AL(2), .BL(BL), .CH(CH), .DW(DW), .FW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_rst_n (bus_rst_n),
        .pio_adr_we(pio_adr_we),
        .pio_d     (pio_d),
        .pio_adr   (pio_adr),
        .pio_len_we(pio_len_we),
        .dma_done  (dma_done),
        .dma_val   (dma_val),
        .dma_rdy   (dma_rdy),
        .dma_eof   (dma_eof),
        .dma_d     (dma_d),
        .bus_rval  (bus_rval),
        .bus_rrdy  (bus_rrdy),
        .bus_rlen  (bus_rlen),
        .bus_raddr (bus_raddr),
        .rsp_val   (rsp_val),
        .rsp_data  (rsp_data)
    );

    int pass_cnt = 0;
    int chk_cnt = 0;

    word_t       exp_q [CH][$];
    logic [31:0] adr_m [CH] = '{default: '0};
    int          rem_m [CH] = '{default: 0};
    int          tot_m [CH] = '{default: 0};
    int          iss_m [CH] = '{default: 0};
    int          occ [CH] = '{default: 0};
    int          popped [CH] = '{default: 0};
    int          eof_at [CH] = '{default: -1};
    int          rr_m = 0;
    bit          busy_m = 0;
    int          cd = -1;
    bit          done_seen = 0;
    int          rval_cycles = 0;
    int          pend_len = 0;
    int          pend_ch = 0;
    int          pend_n = 0;
    int          pend_dly = 0;
    logic [31:0] pend_a = '0;
    bit          stray_en = 0;
    bit          hold = 0;
    logic [31:0] h_addr;
    logic [BL:0] h_len;
    logic [31:0] acc_a [$];
    int          acc_l [$];
    int          m_p, m_rl, m_k;
    bit          m_clr;
    word_t       m_w;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // Model and compare: everything seen at a negedge is what the next posedge samples.
    always @(negedge clk) begin
        if (rst_n) begin
            m_clr = 0;
            for (int k = 0; k < CH; k++) begin
                chk("pio_adr", pio_adr[k*32 +: 32], adr_m[k]);
                if (!dma_val[k]) chk("eof_without_val", dma_eof[k], 0);
            end
            if (cd > 0) cd--;
            chk("dma_done", dma_done, cd == 0);
            if (cd == 0) begin
                cd = -1;
                m_clr = 1;
                done_seen = 1;
            end
            if (hold) begin
                chk("rval_hold", bus_rval, 1);
                chk("raddr_hold", bus_raddr, h_addr);
                chk("rlen_hold", bus_rlen, h_len);
            end
            hold = 0;
            if (bus_rval) rval_cycles++;
            for (int k = 0; k < CH; k++) begin
                if (dma_val[k] && dma_rdy[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk("pop_unexpected", 1, 0);
                    end else begin
                        m_w = exp_q[k].pop_front();
                        chk("dma_d", dma_d[k*DW +: DW], m_w.d);
                        chk("dma_eof", dma_eof[k], m_w.e);
                        if (m_w.e) eof_at[k] = popped[k];
                    end
                    popped[k]++;
                    occ[k]--;
                end
            end
            if (!bus_rst_n) begin
                for (int i = 0; i < pend_len; i++) void'(exp_q[pend_ch].pop_back());
                pend_len = 0;
                for (int k = 0; k < CH; k++) rem_m[k] = 0;
                rr_m = 0;
                cd = -1;
                m_clr = 1;
                rsp_val = 0;
            end else begin
                if (pend_len > 0 && pend_dly == 0) begin
                    rsp_val = 1;
                    rsp_data = data_of(pend_a);
                    pend_a += 4;
                    pend_len--;
                    pend_n++;
                    occ[pend_ch]++;
                    pend_dly = (pend_n == 2) ? 1 : 0;
                    if (pend_len == 0) begin
                        m_k = 0;
                        for (int k = 0; k < CH; k++) m_k += rem_m[k];
                        if (m_k == 0) cd = 2;
                    end
                end else begin
                    if (pend_len > 0) pend_dly--;
                    rsp_val = stray_en && pend_len == 0;
                    rsp_data = 32'hDEAD_BEEF;
                end
                if (bus_rval && bus_rrdy) begin
                    m_p = -1;
                    for (int i = 0; i < CH; i++) begin
                        m_k = (rr_m + i) % CH;
                        m_rl = rem_m[m_k] < 8 ? rem_m[m_k] : 8;
                        if (m_p < 0 && rem_m[m_k] > 0 && 256 - occ[m_k] >= m_rl) m_p = m_k;
                    end
                    if (m_p < 0) begin
                        chk("unexpected_req", 1, 0);
                    end else begin
                        m_rl = rem_m[m_p] < 8 ? rem_m[m_p] : 8;
                        chk("bus_raddr", bus_raddr, adr_m[m_p]);
                        chk("bus_rlen", bus_rlen, m_rl);
                        acc_a.push_back(bus_raddr);
                        acc_l.push_back(int'(bus_rlen));
                        for (int i = 0; i < m_rl; i++) begin
                            iss_m[m_p]++;
                            m_w.d = data_of(adr_m[m_p] + 32'(4 * i));
                            m_w.e = iss_m[m_p] == tot_m[m_p];
                            exp_q[m_p].push_back(m_w);
                        end
                        adr_m[m_p] += 32'(4 * m_rl);
                        rem_m[m_p] -= m_rl;
                        rr_m = (m_p + 1) % CH;
                        pend_len = m_rl;
                        pend_ch = m_p;
                        pend_a = bus_raddr;
                        pend_n = 0;
                        pend_dly = 1;
                    end
                end else if (bus_rval) begin
                    hold = 1;
                    h_addr = bus_raddr;
                    h_len = bus_rlen;
                end
                if (!busy_m) begin
                    for (int k = 0; k < CH; k++)
                        if (pio_adr_we[k]) adr_m[k] = pio_d & ~32'h3;
                    if (pio_len_we) begin
                        busy_m = 1;
                        for (int k = 0; k < CH; k++) begin
                            rem_m[k] = int'(pio_d[11:0]);
                            tot_m[k] = int'(pio_d[11:0]);
                            iss_m[k] = 0;
                        end
                        if (pio_d[11:0] == 0) cd = 2;
                    end
                end
            end
            if (m_clr) busy_m = 0;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_adr(input int k, input logic [31:0] a);
        pio_adr_we[k] = 1'b1;
        pio_d = a;
        cyc();
        pio_adr_we = '0;
    endtask

    task automatic start(input logic [31:0] len);
        done_seen = 0;
        for (int k = 0; k < CH; k++) begin
            popped[k] = 0;
            eof_at[k] = -1;
        end
        pio_len_we = 1'b1;
        pio_d = len;
        cyc();
        pio_len_we = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        for (int i = 0; i < budget && !done_seen; i++) cyc();
        chk(nm, done_seen, 1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q[0].size() + exp_q[1].size()) != 0; i++) cyc();
        chk("drain", exp_q[0].size() + exp_q[1].size(), 0);
        cyc(2);
    endtask

    logic [31:0] s1_a [4] = '{32'h1000, 32'h2000, 32'h1020, 32'h2020};
    int          s1_l [4] = '{8, 8, 2, 2};
    int          base;
    int          n0;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        chk("rst_dma_val", dma_val, 0);
        chk("rst_dma_eof", dma_eof, 0);
        chk("rst_bus_rval", bus_rval, 0);
        chk("rst_dma_done", dma_done, 0);
        chk("rst_pio_adr", pio_adr, 0);
        chk("rst_bus_raddr", bus_raddr, 0);
        chk("rst_bus_rlen", bus_rlen, 0);
        rst_n = 1'b1;
        cyc(2);

        // two channels, len 10, strays on the response bus outside DATA
        stray_en = 1;
        set_adr(0, 32'h1000);
        set_adr(1, 32'h2000);
        base = acc_a.size();
        start(10);
        wait_done(500, "s1_done");
        drain(200);
        stray_en = 0;
        chk("s1_bursts", acc_a.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("s1_addr", acc_a[base + i], s1_a[i]);
            chk("s1_len", acc_l[base + i], s1_l[i]);
        end
        chk("s1_adr0", pio_adr[31:0], 32'h1028);
        chk("s1_adr1", pio_adr[63:32], 32'h2028);
        chk("s1_eof0", eof_at[0], 9);
        chk("s1_eof1", eof_at[1], 9);
        chk("s1_words0", popped[0], 10);

        // length zero
        n0 = rval_cycles;
        start(0);
        chk("s2_done_c1", dma_done, 0);
        cyc();
        chk("s2_done_c2", dma_done, 1);
        cyc();
        chk("s2_done_c3", dma_done, 0);
        cyc(5);
        chk("s2_no_rval", rval_cycles, n0);

        // address wrap
        set_adr(0, 32'hFFFF_FFF8);
        set_adr(1, 32'h3000);
        base = acc_a.size();
        start(4);
        wait_done(300, "s6a_done");
        drain(100);
        chk("s6a_addr0", acc_a[base], 32'hFFFF_FFF8);
        chk("s6a_len0", acc_l[base], 4);
        chk("s6a_adr0", pio_adr[31:0], 32'h0000_0008);
        set_adr(0, 32'hFFFF_FFE3);
        set_adr(1, 32'h4000);
        base = acc_a.size();
        start(10);
        wait_done(500, "s6b_done");
        drain(200);
        chk("s6b_first", acc_a[base], 32'hFFFF_FFE0);
        chk("s6b_wrap", acc_a[base + 2], 32'h0000_0000);
        chk("s6b_adr0", pio_adr[31:0], 32'h0000_0008);

        // request stall
        bus_rrdy = 1'b0;
        set_adr(0, 32'h5000);
        set_adr(1, 32'h6000);
        base = acc_a.size();
        start(8);
        cyc(7);
        chk("s4_rval", bus_rval, 1);
        chk("s4_raddr", bus_raddr, 32'h5000);
        chk("s4_rlen", bus_rlen, 8);
        chk("s4_none_yet", acc_a.size() - base, 0);
        bus_rrdy = 1'b1;
        cyc();
        chk("s4_one", acc_a.size() - base, 1);
        wait_done(500, "s4_done");
        drain(200);
        chk("s4_bursts", acc_a.size() - base, 2);

        // bus abort mid-burst, then restart
        set_adr(0, 32'h7000);
        set_adr(1, 32'h8000);
        start(20);
        for (int i = 0; i < 200 && !(pend_n >= 2 && pend_len > 0); i++) cyc();
        chk("s5_in_data", pend_len > 0, 1);
        bus_rst_n = 1'b0;
        cyc();
        bus_rst_n = 1'b1;
        base = acc_a.size();
        cyc(20);
        chk("s5_no_req", acc_a.size() - base, 0);
        chk("s5_rval", bus_rval, 0);
        chk("s5_no_done", done_seen, 0);
        chk("s5_adr_kept", pio_adr[31:0], 32'h7020);
        drain(100);
        start(6);
        wait_done(400, "s5_restart_done");
        drain(100);
        chk("s5_rr_reset", acc_a[base], 32'h7020);
        chk("s5_second", acc_a[base + 1], 32'h8000);

        // channel 0 back-pressured until its FIFO fills
        dma_rdy = 2'b10;
        set_adr(0, 32'h1_0000);
        set_adr(1, 32'h2_0000);
        start(300);
        for (int i = 0; i < 4000 && popped[1] < 300; i++) cyc();
        chk("s3_ch1_words", popped[1], 300);
        cyc(30);
        base = acc_a.size();
        cyc(20);
        chk("s3_stalled", acc_a.size() - base, 0);
        chk("s3_occ0", occ[0], 256);
        chk("s3_val0", dma_val[0], 1);
        chk("s3_adr0", pio_adr[31:0], 32'h1_0400);
        chk("s3_eof1", eof_at[1], 299);
        chk("s3_no_done", done_seen, 0);
        dma_rdy = 2'b11;
        wait_done(1500, "s3_done");
        drain(400);
        chk("s3_ch0_words", popped[0], 300);
        chk("s3_eof0", eof_at[0], 299);
        chk("s3_adr0_final", pio_adr[31:0], 32'h1_04B0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
